// File: rtl/imm_encoder.sv
// RV32I immediate packer: merges a 32-bit immediate into an instruction template.
// Two-stage valid/ready pipeline; define IMM_RANGE_CHECK_EN to enable range/alignment errors.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_template,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_imm_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_U = 3'b011;
    localparam logic [2:0] SEL_J = 3'b100;

    logic             s1_valid_reg;
    logic [31:0]      s1_template_reg;
    logic [31:0]      s1_imm_reg;
    logic [2:0]       s1_sel_reg;
    logic             s2_valid_reg;
    logic [31:0]      s2_instr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic [31:0]      instr_next;

    // S2 can take a new item when it is empty or being drained this cycle.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_reg && out_ready;

    always_comb begin
        instr_next = s1_template_reg;
        case (s1_sel_reg)
            SEL_I: instr_next = {s1_imm_reg[11:0], s1_template_reg[19:0]};
            SEL_S: instr_next = {s1_imm_reg[11:5], s1_template_reg[24:12],
                                 s1_imm_reg[4:0], s1_template_reg[6:0]};
            SEL_B: instr_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_template_reg[24:12],
                                 s1_imm_reg[4:1], s1_imm_reg[11], s1_template_reg[6:0]};
            SEL_U: instr_next = {s1_imm_reg[31:12], s1_template_reg[11:0]};
            SEL_J: instr_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                 s1_imm_reg[19:12], s1_template_reg[11:0]};
            default: instr_next = s1_template_reg;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic s2_err_reg;
    logic err_next;

    // An immediate fits when all bits above the field's sign bit match it.
    always_comb begin
        err_next = 1'b1;
        case (s1_sel_reg)
            SEL_I, SEL_S: err_next = !((&s1_imm_reg[31:11]) || !(|s1_imm_reg[31:11]));
            SEL_B: err_next = !((&s1_imm_reg[31:12]) || !(|s1_imm_reg[31:12])) || s1_imm_reg[0];
            SEL_J: err_next = !((&s1_imm_reg[31:20]) || !(|s1_imm_reg[31:20])) || s1_imm_reg[0];
            SEL_U: err_next = |s1_imm_reg[11:0];
            default: err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_err_reg <= 1'b0;
        end else if (!flush && s2_load && s1_valid_reg) begin
            s2_err_reg <= err_next;
        end
    end

    assign out_err = s2_err_reg;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_template_reg <= '0;
            s1_imm_reg      <= '0;
            s1_sel_reg      <= '0;
            s2_valid_reg    <= 1'b0;
            s2_instr_reg    <= '0;
            count_reg       <= '0;
        end else begin
            if (out_fire) begin
                count_reg <= count_reg + 1'b1;
            end
            if (flush) begin
                s1_valid_reg <= 1'b0;
                s2_valid_reg <= 1'b0;
            end else begin
                if (s2_load) begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_instr_reg <= instr_next;
                    end
                end
                if (in_ready) begin
                    s1_valid_reg <= in_valid;
                end
                if (in_fire) begin
                    s1_template_reg <= in_template;
                    s1_imm_reg      <= in_imm;
                    s1_sel_reg      <= in_imm_sel;
                end
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_instr = s2_instr_reg;
    assign enc_count = count_reg;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate generator: packs a 32-bit immediate into the immediate bit positions of an RV32I instruction template.
- Produces the final 32-bit instruction word and a range-violation flag.
- Sits between the debug/instruction-injection path (or the boot/test program loader) and instruction memory.
- Two-stage valid/ready pipeline with backpressure, flush and a handshake counter.

Parameters:
CNT_W, 16, width of the encoded-instruction counter (wraps)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous pipeline flush, drops all in-flight items
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
in_template  input  32  instruction with opcode/rd/rs/funct fields set; immediate bits don't-care
in_imm  input  32  immediate to pack (byte offset for B/J)
in_imm_sel  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 invalid
out_valid  output  1  encoded instruction valid
out_ready  input  1  consumer accepts
out_instr  output  32  encoded instruction
out_err  output  1  immediate not representable or sel invalid
enc_count  output  CNT_W  number of output handshakes, wraps modulo 2^CNT_W

Behaviour:
Reset (rst=1 at an edge):
- Both stage-valid flags clear; out_valid=0, out_instr=0, out_err=0, enc_count=0.
- in_ready=1 from the first cycle after reset. rst overrides flush and all handshakes.

Pipeline:
- S1 registers the request and computes packing and error. S2 is the output register.
- Latency: exactly 2 cycles from input handshake to out_valid with out_ready held high.
- Throughput: 1 per cycle.

Handshake rules:
- Input accepted when in_valid && in_ready.
- Output consumed when out_valid && out_ready.
- S2 loads when empty or consumed; S1 advances into S2 under the same condition.
- in_ready = !s1_valid || S1 advancing. Combinational from out_ready; no combinational path from in_valid.
- While out_valid && !out_ready, out_instr and out_err hold stable.
- Order is preserved; no drop or duplication.

flush:
- Clears both valid flags at the edge. Any input handshake in the same cycle is discarded.
- enc_count is unchanged.
- An output handshake in the flush cycle still counts.

Packing: clear the immediate field in the template, then OR in the immediate bits. All other template bits pass through unchanged.
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Invalid sel: out_instr = template unchanged.

Error (out_err=1):
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0]!=0.
- Any invalid sel (101-111).
- On error the item is still emitted, packed from truncated bits, and counted.

Counter: enc_count increments by 1 per output handshake and wraps from all-ones to 0.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: error rules above apply; out_err is registered with the data.
- Undefined: no range/alignment logic; out_err is constant 0, including for invalid sel. Packing, latency and handshake are identical.

Test Plan:
- I-type: template 0x00000093, imm 0xFFFFFFFF, sel 000, out_ready=1 -> 2 cycles later out_instr 0xFFF00093, out_err 0, enc_count 1.
- S/B-type:
  - S: template 0x00002023, imm 0xFFFFF804, sel 001 -> 0x80002223, err 0.
  - B: template 0x00000063, imm 0xFFFFFFFE, sel 010 -> 0xFE000FE3, err 0.
  - B odd: same template, imm 0x00000003 -> err 1 (macro on), err 0 (macro off).
- J/U range:
  - J: template 0x000000EF, imm 0x00000800, sel 100 -> 0x001000EF, err 0.
  - J out of range: imm 0x00100000 -> err 1.
  - U: template 0x00000037, imm 0x12345000, sel 011 -> 0x12345037, err 0.
  - U misaligned: imm 0x12345001 -> 0x12345037, err 1.
  - Invalid sel: sel 111 -> template unchanged, err 1.
- Backpressure: issue items A, B, C back-to-back with out_ready=0 -> out_valid high with A stable, in_ready=0 after A and B accepted, C stalled. Release out_ready -> A, B, C in order on consecutive cycles, enc_count +3.
- Flush/reset:
  - Two items in flight, flush=1 for one cycle -> out_valid=0 next cycle, enc_count unchanged, next request emerges 2 cycles after acceptance.
  - rst mid-stream -> all outputs return to reset values.
- Counter wrap: with CNT_W=4, 17 handshakes -> enc_count=1.
